// File: rtl/uart_tx_scheduler_pkg.sv
// uart_sched_pkg: FSM encoding, width helpers and round-robin grant for uart_tx_scheduler
package uart_sched_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_e;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  // First requesting channel strictly after last, wrapping; caller guarantees some req bit is set.
  function automatic int next_grant(input logic [7:0] req, input int last, input int n);
    int g;
    g = last;
    for (int k = n; k >= 1; k--) if (req[(last + k) % n]) g = (last + k) % n;
    return g;
  endfunction
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: producer pushes, FIFO status, UART byte handshake and sticky flags
// master = producers/UART side, slave = scheduler
interface uart_tx_scheduler_if
  import uart_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  logic [NUM_CH-1:0] in_valid, fifo_full, fifo_empty, overflow;
  logic [NUM_CH*DATA_W-1:0] in_bits;
  logic [DATA_W-1:0] tx_bits;
  logic tx_ready, tx_busy, timeout, clear_flags;
  logic [ch_w(NUM_CH)-1:0] last_ch;
  modport master (
    output in_valid, in_bits, tx_ready, clear_flags,
    input fifo_full, fifo_empty, tx_bits, tx_busy, last_ch, overflow, timeout
  );
  modport slave (
    input in_valid, in_bits, tx_ready, clear_flags,
    output fifo_full, fifo_empty, tx_bits, tx_busy, last_ch, overflow, timeout
  );
endinterface

// File: rtl/uart_tx_scheduler_byte_fifo.sv
// byte_fifo: DEPTH-entry FIFO with wrap-bit pointers; clock, reset_n, push, pop, din -> dout (head), full, empty
// Caller only pushes when accepted and only pops when non-empty.
module byte_fifo
  import uart_sched_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PW = ptr_w(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[PW-2:0] == rd_q[PW-2:0]);
  assign dout  = mem_q[rd_q[PW-2:0]];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + PW'(push);
      rd_q <= rd_q + PW'(pop);
    end
  always_ff @(posedge clock)
    if (push) mem_q[wr_q[PW-2:0]] <= din;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin scheduler of NUM_CH byte FIFOs onto a UART transmit handshake
// Ports: clock, reset_n (async active-low), bus (slave modport: pushes, FIFO status, tx_bits/tx_ready/tx_busy,
// last_ch, sticky overflow/timeout, clear_flags). Define TX_DEDUP_EN to drop repeats of a channel's last accepted byte.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic clock,
  input logic reset_n,
  uart_tx_scheduler_if.slave bus
);
  localparam int CW = ch_w(NUM_CH);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  state_e state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [CW-1:0] last_q, last_d, grant;
  logic [TW-1:0] timer_q, timer_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d, ovf_set, push, pop, full, empty;
  logic to_q, to_d, expire, busy;
  logic [DATA_W-1:0] head [NUM_CH];
  assign busy   = state_q == WAIT_ACK;
  assign grant  = CW'(next_grant(8'(~empty), int'(last_q), NUM_CH));
  assign expire = (TIMEOUT_CYC != 0) && (timer_q == TW'(TIMEOUT_CYC - 1));
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic dup;
`ifdef TX_DEDUP_EN
    logic [DATA_W-1:0] lb_q;
    logic lv_q;
    assign dup = lv_q && bus.in_bits[i*DATA_W +: DATA_W] == lb_q;
    // The remembered byte stays valid while it is queued or is the byte in flight.
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
        lb_q <= '0;
        lv_q <= 1'b0;
      end else if (push[i]) begin
        lb_q <= bus.in_bits[i*DATA_W +: DATA_W];
        lv_q <= 1'b1;
      end else if (empty[i] && !(busy && last_q == CW'(i))) lv_q <= 1'b0;
`else
    assign dup = 1'b0;
`endif
    assign push[i]    = bus.in_valid[i] && !dup && (!full[i] || pop[i]);
    assign ovf_set[i] = bus.in_valid[i] && !dup && full[i] && !pop[i];
    byte_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clock(clock), .reset_n(reset_n), .push(push[i]), .pop(pop[i]),
      .din(bus.in_bits[i*DATA_W +: DATA_W]), .dout(head[i]), .full(full[i]), .empty(empty[i])
    );
  end
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    last_d  = last_q;
    timer_d = timer_q + TW'(1);
    pop     = '0;
    ovf_d   = (bus.clear_flags ? '0 : ovf_q) | ovf_set;
    to_d    = bus.clear_flags ? 1'b0 : to_q;
    if (state_q == IDLE) begin
      if (!(&empty)) begin
        state_d    = WAIT_ACK;
        tx_d       = head[grant];
        last_d     = grant;
        timer_d    = '0;
        pop[grant] = 1'b1;
      end
    end else if (bus.tx_ready) state_d = IDLE;
    else if (expire) begin
      state_d = IDLE;
      to_d    = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      last_q  <= CW'(NUM_CH - 1);
      timer_q <= '0;
      ovf_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
    end
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.tx_bits    = tx_q;
  assign bus.tx_busy    = busy;
  assign bus.last_ch    = last_q;
  assign bus.overflow   = ovf_q;
  assign bus.timeout    = to_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed checks of reset, round-robin order, overflow, timeout, mid-transfer reset and dedup
module tb_uart_tx_scheduler;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int ncmp = 0;
  int nerr = 0;
  uart_tx_scheduler_if #(.NUM_CH(4), .DATA_W(8)) bus ();
  uart_tx_scheduler #(.NUM_CH(4), .FIFO_DEPTH(4), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    bus.in_valid = '0;
    bus.in_bits = '0;
    bus.tx_ready = 1'b0;
    bus.clear_flags = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask
  task automatic ack();
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
  endtask
  logic [7:0] exp_q [$];
  initial begin
    do_reset();
    reset_n = 1'b0;
    step();
    chk("rst_tx_bits", 32'(bus.tx_bits), 32'h0);
    chk("rst_busy", 32'(bus.tx_busy), 32'h0);
    chk("rst_last_ch", 32'(bus.last_ch), 32'h3);
    chk("rst_empty", 32'(bus.fifo_empty), 32'hF);
    chk("rst_full", 32'(bus.fifo_full), 32'h0);
    chk("rst_flags", {bus.timeout, 27'(bus.overflow)}, 32'h0);
    reset_n = 1'b1;
    step();
    // single byte latency
    bus.in_bits = 32'h000000A1;
    bus.in_valid = 4'b0001;
    step();
    bus.in_valid = '0;
    chk("t1_empty_after_push", 32'(bus.fifo_empty), 32'hE);
    chk("t1_not_busy_yet", 32'(bus.tx_busy), 32'h0);
    step();
    chk("t1_tx_bits", 32'(bus.tx_bits), 32'hA1);
    chk("t1_busy", 32'(bus.tx_busy), 32'h1);
    chk("t1_last_ch", 32'(bus.last_ch), 32'h0);
    ack();
    chk("t1_idle_after_ack", 32'(bus.tx_busy), 32'h0);
    chk("t1_tx_hold", 32'(bus.tx_bits), 32'hA1);
    // round robin across all channels
    do_reset();
    bus.in_bits = 32'h40302010;
    bus.in_valid = 4'hF;
    step();
    bus.in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t2_tx_bits_%0d", k), 32'(bus.tx_bits), 32'(8'h10 * (k + 1)));
      chk($sformatf("t2_last_ch_%0d", k), 32'(bus.last_ch), 32'(k));
      ack();
      chk($sformatf("t2_idle_%0d", k), 32'(bus.tx_busy), 32'h0);
    end
    // overflow on ch1 while the scheduler is stuck on a ch0 byte
    do_reset();
    bus.in_bits = 32'h00000077;
    bus.in_valid = 4'b0001;
    step();
    bus.in_valid = '0;
    step();
    for (int k = 1; k <= 5; k++) begin
      bus.in_bits = 32'(k) << 8;
      bus.in_valid = 4'b0010;
      step();
    end
    bus.in_valid = '0;
    chk("t3_full", 32'(bus.fifo_full), 32'h2);
    chk("t3_overflow", 32'(bus.overflow), 32'h2);
    chk("t3_empty", 32'(bus.fifo_empty), 32'hD);
    bus.clear_flags = 1'b1;
    step();
    bus.clear_flags = 1'b0;
    chk("t3_overflow_clr", 32'(bus.overflow), 32'h0);
    ack();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t3_drain_%0d", k), 32'(bus.tx_bits), 32'(k));
      chk($sformatf("t3_drain_ch_%0d", k), 32'(bus.last_ch), 32'h1);
      ack();
    end
    chk("t3_all_empty", 32'(bus.fifo_empty), 32'hF);
    // ack timeout
    do_reset();
    bus.in_bits = 32'hC3B20000;
    bus.in_valid = 4'b1100;
    step();
    bus.in_valid = '0;
    step();
    chk("t4_first", 32'(bus.tx_bits), 32'hB2);
    repeat (15) step();
    chk("t4_still_waiting", {bus.timeout, 30'd0, bus.tx_busy}, 32'h1);
    step();
    chk("t4_timeout", 32'(bus.timeout), 32'h1);
    chk("t4_idle", 32'(bus.tx_busy), 32'h0);
    step();
    chk("t4_next_byte", 32'(bus.tx_bits), 32'hC3);
    chk("t4_next_ch", 32'(bus.last_ch), 32'h3);
    chk("t4_next_busy", 32'(bus.tx_busy), 32'h1);
    // reset in the middle of a transfer
    do_reset();
    bus.in_bits = 32'h44332211;
    bus.in_valid = 4'hF;
    step();
    bus.in_valid = '0;
    step();
    chk("t5_busy_before", 32'(bus.tx_busy), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("t5_async_busy", 32'(bus.tx_busy), 32'h0);
    chk("t5_async_tx", 32'(bus.tx_bits), 32'h0);
    chk("t5_async_last", 32'(bus.last_ch), 32'h3);
    chk("t5_async_empty", 32'(bus.fifo_empty), 32'hF);
    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("t5_no_send", 32'(bus.tx_busy), 32'h0);
    chk("t5_empty_after", 32'(bus.fifo_empty), 32'hF);
    // repeated byte on ch2
    do_reset();
    bus.in_valid = 4'b0100;
    bus.in_bits = 32'h00550000;
    step();
    step();
    bus.in_bits = 32'h00660000;
    step();
    bus.in_valid = '0;
`ifdef TX_DEDUP_EN
    exp_q = '{8'h55, 8'h66};
`else
    exp_q = '{8'h55, 8'h55, 8'h66};
`endif
    foreach (exp_q[k]) begin
      if (k != 0) step();
      chk($sformatf("t6_tx_%0d", k), 32'(bus.tx_bits), 32'(exp_q[k]));
      chk($sformatf("t6_ch_%0d", k), 32'(bus.last_ch), 32'h2);
      ack();
    end
    step();
    chk("t6_done", 32'(bus.tx_busy), 32'h0);
    chk("t6_no_overflow", 32'(bus.overflow), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
